// File: rtl/dll_update_ctrl.sv
// Bring-up, lock supervision and delay-code update sequencer for one DLL primitive.
// Optional periodic self-update is compiled in with `define DLL_UPD_PERIODIC_EN.
module dll_update_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int UNLOCK_FILTER = 4,
  parameter int UPD_PULSE     = 2,
  parameter int UPD_PERIOD    = 1024,
  parameter int CNT_W         = 16
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       START,
  input  logic       DLL_LOCK,
  input  logic [5:0] DLL_DCNTL,
  input  logic       UPD_REQ,
  output logic       DLL_RSTN,
  output logic       DLL_ALUHOLD,
  output logic       DLL_UDDCNTL,
  output logic       UPD_ACK,
  output logic       READY,
  output logic [5:0] DCNTL_OUT,
  output logic       ERR,
  output logic [2:0] STATE
);

  // Handshake: UPD_REQ is a level held by the requester until it sees the
  // one-cycle UPD_ACK; the request is sampled into req_q and acted on one
  // edge later, and the ACK cycle itself never starts a new update.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RSTDLL    = 3'd1,
    S_WAITLK    = 3'd2,
    S_LOCKED    = 3'd3,
    S_UPD_HOLD  = 3'd4,
    S_UPD_PULSE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] UNL_LAST   = CNT_W'(UNLOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(UPD_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] unl_q, unl_d;
  logic             lock_s1_q, lock_s2_q;
  logic             req_q;
  logic             done_q, done_d;
  logic             by_req_q, by_req_d;
  logic             rstn_q, rstn_d;
  logic             hold_q, hold_d;
  logic             udd_q, udd_d;
  logic             ack_q, ack_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [5:0]       dcntl_q, dcntl_d;
  logic             in_upd;
  logic             lock_lost;
  logic             trig_timer;

  assign in_upd = (state_q == S_LOCKED) || (state_q == S_UPD_HOLD) ||
                  (state_q == S_UPD_PULSE);

  // Lock-loss filter: consecutive low samples of the synced lock; any high clears it.
  always_comb begin
    unl_d     = '0;
    lock_lost = 1'b0;
    if (in_upd && !lock_s2_q) begin
      if (unl_q == UNL_LAST) lock_lost = 1'b1;
      else                   unl_d     = sat_inc(unl_q);
    end
  end

`ifdef DLL_UPD_PERIODIC_EN
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(UPD_PERIOD - 1);
  logic [CNT_W-1:0] tmr_q, tmr_d;

  // Counts only in settled LOCKED; the completion cycle belongs to the update.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != S_LOCKED)                   tmr_d = '0;
    else if (state_q == S_LOCKED && !done_q)   tmr_d = sat_inc(tmr_q);
  end

  assign trig_timer = (tmr_q == PERIOD_LAST);

  always_ff @(posedge CLKI) begin
    if (RST) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  logic unused_period;
  assign unused_period = (UPD_PERIOD != 0);
  assign trig_timer    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    by_req_d = by_req_q;
    dcntl_d  = dcntl_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_RSTDLL;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_RSTDLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAITLK;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_WAITLK: begin
        if (lock_s2_q) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      S_LOCKED: begin
        if (lock_lost) begin
          state_d = S_WAITLK;
          cnt_d   = '0;
        end else if (!done_q && (req_q || trig_timer)) begin
          state_d  = S_UPD_HOLD;
          by_req_d = req_q;
        end
      end
      S_UPD_HOLD: begin
        state_d = lock_lost ? S_WAITLK : S_UPD_PULSE;
        cnt_d   = '0;
      end
      S_UPD_PULSE: begin
        if (lock_lost) begin
          state_d = S_WAITLK;
          cnt_d   = '0;
        end else if (cnt_q == PULSE_LAST) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
          done_d  = 1'b1;
          dcntl_d = DLL_DCNTL;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // DLL-side outputs are registered images of the next state.
  always_comb begin
    rstn_d  = (state_d != S_IDLE) && (state_d != S_RSTDLL);
    hold_d  = (state_d != S_WAITLK) && (state_d != S_LOCKED);
    udd_d   = (state_d == S_UPD_PULSE);
    ready_d = (state_d == S_LOCKED);
    ack_d   = done_d && by_req_q;
  end

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      unl_q     <= '0;
      lock_s1_q <= 1'b0;
      lock_s2_q <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      by_req_q  <= 1'b0;
      rstn_q    <= 1'b0;
      hold_q    <= 1'b1;
      udd_q     <= 1'b0;
      ack_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      dcntl_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      unl_q     <= unl_d;
      lock_s1_q <= DLL_LOCK;
      lock_s2_q <= lock_s1_q;
      req_q     <= UPD_REQ;
      done_q    <= done_d;
      by_req_q  <= by_req_d;
      rstn_q    <= rstn_d;
      hold_q    <= hold_d;
      udd_q     <= udd_d;
      ack_q     <= ack_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      dcntl_q   <= dcntl_d;
    end
  end

  assign DLL_RSTN    = rstn_q;
  assign DLL_ALUHOLD = hold_q;
  assign DLL_UDDCNTL = udd_q;
  assign UPD_ACK     = ack_q;
  assign READY       = ready_q;
  assign DCNTL_OUT   = dcntl_q;
  assign ERR         = err_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_dll_update_ctrl.sv
// Directed bench for dll_update_ctrl: bring-up, timeout, updates, lock loss, reset.
// Expected UPD_ACK events (code and cycle) are queued by the driver and popped by a monitor.
module tb_dll_update_ctrl;

`ifdef DLL_UPD_PERIODIC_EN
  localparam int TB_PERIOD = 64;
`else
  localparam int TB_PERIOD = 1024;
`endif

  // {STATE, RSTN, ALUHOLD, UDDCNTL, ACK, READY, DCNTL_OUT, ERR}
  localparam logic [14:0] RST_OUTS = 15'b000_0_1_0_0_0_000000_0;

  logic       CLKI = 1'b0;
  logic       RST;
  logic       START;
  logic       DLL_LOCK;
  logic [5:0] DLL_DCNTL;
  logic       UPD_REQ;
  logic       DLL_RSTN;
  logic       DLL_ALUHOLD;
  logic       DLL_UDDCNTL;
  logic       UPD_ACK;
  logic       READY;
  logic [5:0] DCNTL_OUT;
  logic       ERR;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [37:0] exp_q[$];  // {code, ack cycle}

  dll_update_ctrl #(.UPD_PERIOD(TB_PERIOD)) dut (
    .CLKI(CLKI), .RST(RST), .START(START), .DLL_LOCK(DLL_LOCK),
    .DLL_DCNTL(DLL_DCNTL), .UPD_REQ(UPD_REQ), .DLL_RSTN(DLL_RSTN),
    .DLL_ALUHOLD(DLL_ALUHOLD), .DLL_UDDCNTL(DLL_UDDCNTL), .UPD_ACK(UPD_ACK),
    .READY(READY), .DCNTL_OUT(DCNTL_OUT), .ERR(ERR), .STATE(STATE)
  );

  // clock / cycle count / watchdog
  always #5 CLKI = ~CLKI;
  always @(posedge CLKI) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] outs();
    return {STATE, DLL_RSTN, DLL_ALUHOLD, DLL_UDDCNTL, UPD_ACK, READY, DCNTL_OUT, ERR};
  endfunction

  // driver helpers
  task automatic wait_rstn_rise(output int at);
    at = -1;
    for (int k = 0; k < 40 && DLL_RSTN !== 1'b1; k++) @(negedge CLKI);
    if (DLL_RSTN === 1'b1) at = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL rstn_rise_timeout actual=0 expected=1 cyc=%0d", cyc);
    end
  endtask

  task automatic wait_ack_then_drop();
    int k;
    for (k = 0; k < 40 && UPD_ACK !== 1'b1; k++) @(negedge CLKI);
    if (UPD_ACK !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_wait_timeout actual=0 expected=1 cyc=%0d", cyc);
    end
    UPD_REQ = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge CLKI) begin
    logic [37:0] e;
    if (UPD_ACK === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 expected=0 cyc=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(e[31:0]));
        check("ack_code", 64'(DCNTL_OUT), 64'(e[37:32]));
      end
    end
  end

  initial begin
    int s, w, n, lk, bad;
    logic [12:0] pat;
    RST = 1'b1; START = 1'b0; DLL_LOCK = 1'b0; DLL_DCNTL = '0; UPD_REQ = 1'b0;
    repeat (3) @(negedge CLKI);
    check("reset_outputs", 64'(outs()), 64'(RST_OUTS));
    RST = 1'b0;
    @(negedge CLKI);
    check("idle_outputs", 64'(outs()), 64'(RST_OUTS));

    // bring-up with lock 50 cycles after DLL_RSTN rises
    START = 1'b1; s = cyc + 1;
    @(negedge CLKI);
    START = 1'b0;
    check("start_to_rstdll", 64'(STATE), 64'(1));
    wait_rstn_rise(w);
    check("rstn_low_cycles", 64'(w - s), 64'(16));
    check("waitlk_outputs", 64'({STATE, DLL_ALUHOLD}), 64'({3'd2, 1'b0}));
    repeat (50) @(negedge CLKI);
    check("waitlk_no_ready", 64'({STATE, READY, ERR}), 64'({3'd2, 1'b0, 1'b0}));
    DLL_LOCK = 1'b1; lk = cyc + 1;
    for (int k = 0; k < 6 && READY !== 1'b1; k++) @(negedge CLKI);
    check("ready_within_3", 64'((READY === 1'b1) && (cyc - lk <= 3)), 64'(1));
    check("locked_state", 64'({STATE, ERR, DLL_ALUHOLD}), 64'({3'd3, 1'b0, 1'b0}));

    // single update, code 2A, exact timing
    DLL_DCNTL = 6'h2A; UPD_REQ = 1'b1; n = cyc + 1;
    exp_q.push_back({6'h2A, 32'(n + 4)});
    @(negedge CLKI);
    check("upd_n", 64'({DLL_ALUHOLD, DLL_UDDCNTL, READY}), 64'(3'b001));
    @(negedge CLKI);
    check("upd_hold", 64'({DLL_ALUHOLD, DLL_UDDCNTL, READY, STATE}), 64'({3'b100, 3'd4}));
    @(negedge CLKI);
    check("upd_pulse1", 64'({DLL_ALUHOLD, DLL_UDDCNTL, READY}), 64'(3'b110));
    @(negedge CLKI);
    check("upd_pulse2", 64'({DLL_ALUHOLD, DLL_UDDCNTL, READY}), 64'(3'b110));
    @(negedge CLKI);
    check("upd_done", 64'({DLL_ALUHOLD, DLL_UDDCNTL, READY, UPD_ACK}), 64'(4'b0011));
    UPD_REQ = 1'b0;
    @(negedge CLKI);
    check("ack_one_cycle", 64'({UPD_ACK, STATE, DCNTL_OUT}), 64'({1'b0, 3'd3, 6'h2A}));

    // request still high in the ACK cycle starts a second update
    DLL_DCNTL = 6'h15; UPD_REQ = 1'b1; n = cyc + 1;
    exp_q.push_back({6'h15, 32'(n + 4)});
    exp_q.push_back({6'h33, 32'(n + 9)});
    repeat (5) @(negedge CLKI);
    DLL_DCNTL = 6'h33;
    repeat (5) @(negedge CLKI);
    UPD_REQ = 1'b0;
    @(negedge CLKI);
    check("b2b_settled", 64'({UPD_ACK, STATE, READY}), 64'({1'b0, 3'd3, 1'b1}));

    // short lock glitches (3 low, 1 high, 3 low) are filtered
    pat = 13'b0001000111111; bad = 0;
    for (int i = 12; i >= 0; i--) begin
      DLL_LOCK = pat[i];
      @(negedge CLKI);
      if (READY !== 1'b1 || STATE !== 3'd3) bad++;
    end
    check("glitch_ready_drops", 64'(bad), 64'(0));

    // lock lost for 4 cycles during UPD_PULSE aborts; pending request completes after relock
    DLL_LOCK = 1'b0; DLL_DCNTL = 6'h0C;
    repeat (2) @(negedge CLKI);
    UPD_REQ = 1'b1; n = cyc + 1;
    exp_q.push_back({6'h0C, 32'(n + 8)});
    repeat (2) @(negedge CLKI);
    DLL_LOCK = 1'b1;
    @(negedge CLKI);
    check("abort_in_pulse", 64'({STATE, DLL_UDDCNTL}), 64'({3'd5, 1'b1}));
    @(negedge CLKI);
    check("abort_to_waitlk", 64'({STATE, DLL_UDDCNTL, READY, DLL_ALUHOLD, DLL_RSTN, UPD_ACK}),
          64'({3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    wait_ack_then_drop();
    @(negedge CLKI);
    check("relock_update_done", 64'({STATE, DCNTL_OUT}), 64'({3'd3, 6'h0C}));

    // RST in the middle of UPD_PULSE
    DLL_DCNTL = 6'h3F; UPD_REQ = 1'b1;
    repeat (3) @(negedge CLKI);
    check("pre_rst_pulse", 64'({STATE, DLL_UDDCNTL}), 64'({3'd5, 1'b1}));
    RST = 1'b1; UPD_REQ = 1'b0;
    @(negedge CLKI);
    check("rst_mid_pulse", 64'(outs()), 64'(RST_OUTS));
    RST = 1'b0; DLL_LOCK = 1'b0;
    @(negedge CLKI);

    // lock timeout; START during WAITLK is ignored
    START = 1'b1;
    @(negedge CLKI);
    START = 1'b0;
    wait_rstn_rise(w);
    while (cyc < w + 4095) begin
      @(negedge CLKI);
      START = (cyc == w + 100);
      if (cyc == w + 101) check("start_ignored", 64'({STATE, DLL_RSTN}), 64'({3'd2, 1'b1}));
    end
    START = 1'b0;
    check("before_timeout", 64'({STATE, ERR}), 64'({3'd2, 1'b0}));
    @(negedge CLKI);
    check("timeout_err", 64'({STATE, ERR, DLL_RSTN, DLL_ALUHOLD}), 64'({3'd0, 1'b1, 1'b0, 1'b1}));
    repeat (3) @(negedge CLKI);
    check("err_sticky", 64'({STATE, ERR}), 64'({3'd0, 1'b1}));

    // next START clears ERR; request raised outside LOCKED is serviced once locked
    DLL_DCNTL = 6'h21; UPD_REQ = 1'b1; START = 1'b1;
    @(negedge CLKI);
    START = 1'b0;
    check("start_clears_err", 64'({STATE, ERR}), 64'({3'd1, 1'b0}));
    wait_rstn_rise(w);
    repeat (5) @(negedge CLKI);
    check("pending_not_serviced", 64'({STATE, DLL_UDDCNTL}), 64'({3'd2, 1'b0}));
    DLL_LOCK = 1'b1; lk = cyc + 1;
    exp_q.push_back({6'h21, 32'(lk + 6)});
    wait_ack_then_drop();
    @(negedge CLKI);

`ifdef DLL_UPD_PERIODIC_EN
    begin
      int r[3];
      int nr;
      logic prev;
      nr = 0; prev = DLL_ALUHOLD;
      for (int k = 0; k < 300 && nr < 3; k++) begin
        @(negedge CLKI);
        if (DLL_ALUHOLD === 1'b1 && prev === 1'b0) begin
          r[nr] = cyc;
          nr++;
        end
        prev = DLL_ALUHOLD;
      end
      check("periodic_rises", 64'(nr), 64'(3));
      if (nr == 3) begin
        check("periodic_interval1", 64'(r[1] - r[0]), 64'(68));
        check("periodic_interval2", 64'(r[2] - r[1]), 64'(68));
      end
    end
`endif

    repeat (5) @(negedge CLKI);
    check("no_pending_acks", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
